// File: rtl/proj_pkg.sv
// Shared genome/kmer types and constants for the FM kmer reader.
package proj_pkg;
  localparam int GENOME_BTYE   = 8;
  localparam int BASE_LEN      = 4;
  localparam int KMER_LEN      = 4;
  localparam int FM_KMER_POS_W = 16;

  typedef logic [BASE_LEN-1:0]          base_t;
  typedef logic [KMER_LEN*BASE_LEN-1:0] kmer_t;

  localparam base_t BASE_A = 4'b0001;
  localparam base_t BASE_C = 4'b0010;
  localparam base_t BASE_G = 4'b0100;
  localparam base_t BASE_T = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } rd_state_e;
endpackage

// File: rtl/fm_kmer_window.sv
// K-base sliding window: newest base enters the low nibble; fill saturates at K.
module fm_kmer_window
  import proj_pkg::*;
#(
  parameter int BASE_W = BASE_LEN,
  parameter int K      = KMER_LEN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                shift_i,
  input  logic                clear_i,
  input  logic [BASE_W-1:0]   base_i,
  output logic [K*BASE_W-1:0] win_nxt_o,
  output logic                full_o
);
  localparam int FW = $clog2(K + 1);

  logic [K*BASE_W-1:0] win_q, win_d;
  logic [FW-1:0]       fill_q, fill_d, fill_inc;

  always_comb begin
    fill_inc  = (fill_q == FW'(K)) ? fill_q : fill_q + 1'b1;
    win_nxt_o = {win_q[(K-1)*BASE_W-1:0], base_i};
    // full reflects the post-shift window, which is what the reader registers
    full_o    = shift_i && (fill_inc == FW'(K));
    win_d     = win_q;
    fill_d    = fill_q;
    if (clear_i) begin
      win_d  = '0;
      fill_d = '0;
    end else if (shift_i) begin
      win_d  = win_nxt_o;
      fill_d = fill_inc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/fm_kmer_reader.sv
// Unpacks genome bytes into one-hot bases and streams K-base kmers with position/last.
// FM_KMER_READER_BASE_CHECK_EN: reject non-one-hot nibbles and raise sticky bad_base.
module fm_kmer_reader
  import proj_pkg::*;
#(
  parameter int BYTE_W = GENOME_BTYE,
  parameter int BASE_W = BASE_LEN,
  parameter int K      = KMER_LEN
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [BYTE_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     kmer_valid,
  input  logic                     kmer_ready,
  output logic [K*BASE_W-1:0]      kmer_data,
  output logic                     kmer_last,
  output logic [FM_KMER_POS_W-1:0] kmer_pos,
  output logic                     frag_short,
  output logic                     bad_base
);
  rd_state_e state_q, state_d;

  logic [BYTE_W-1:0]        byte_q;
  logic                     last_q;
  logic [FM_KMER_POS_W-1:0] pos_q;
  logic                     kv_q, kl_q, fs_q;
  logic [K*BASE_W-1:0]      kd_q;
  logic [FM_KMER_POS_W-1:0] kp_q;

  logic                advance, accept, hi_base, frag_end, base_ok;
  logic                do_shift, do_clear, full;
  logic [BASE_W-1:0]   base;
  logic [K*BASE_W-1:0] win_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)  state_d = ST_LO;
      ST_LO:   if (advance) state_d = ST_HI;
      ST_HI:   if (advance) state_d = accept ? ST_LO : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    advance  = (state_q != ST_IDLE) && (!kv_q || kmer_ready);
    in_ready = !rst && ((state_q == ST_IDLE) || ((state_q == ST_HI) && advance));
    accept   = in_valid && in_ready;
    hi_base  = (state_q == ST_HI);
    base     = hi_base ? byte_q[2*BASE_W-1:BASE_W] : byte_q[BASE_W-1:0];
    frag_end = advance && hi_base && last_q;
    do_shift = advance && base_ok;
    do_clear = frag_end || (advance && !base_ok);
  end

`ifdef FM_KMER_READER_BASE_CHECK_EN
  logic bad_q;
  assign base_ok = (base != '0) && ((base & (base - 1'b1)) == '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      bad_q <= 1'b0;
    else if (advance && !base_ok) bad_q <= 1'b1;
  end
  assign bad_base = bad_q;
`else
  assign base_ok  = 1'b1;
  assign bad_base = 1'b0;
`endif

  fm_kmer_window #(.BASE_W(BASE_W), .K(K)) u_win (
    .clk       (clk),
    .rst       (rst),
    .shift_i   (do_shift),
    .clear_i   (do_clear),
    .base_i    (base),
    .win_nxt_o (win_nxt),
    .full_o    (full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_q <= '0;
      last_q <= 1'b0;
      pos_q  <= '0;
      kv_q   <= 1'b0;
      kd_q   <= '0;
      kp_q   <= '0;
      kl_q   <= 1'b0;
      fs_q   <= 1'b0;
    end else begin
      if (accept) begin
        byte_q <= in_data;
        last_q <= in_last;
      end
      fs_q <= frag_end && !full;
      // advance only happens once any previous kmer has been taken
      if (advance) begin
        kv_q <= full;
        if (full) begin
          kd_q <= win_nxt;
          kp_q <= pos_q;
          kl_q <= frag_end;
        end
      end else if (kv_q && kmer_ready) begin
        kv_q <= 1'b0;
      end
      if (frag_end)  pos_q <= '0;
      else if (full) pos_q <= pos_q + 1'b1;
    end
  end

  assign kmer_valid = kv_q;
  assign kmer_data  = kd_q;
  assign kmer_pos   = kp_q;
  assign kmer_last  = kl_q;
  assign frag_short = fs_q;
endmodule

// File: tb/tb_fm_kmer_reader.sv
// Directed + randomized bench for fm_kmer_reader against a queue-based kmer model.
module tb_fm_kmer_reader;
  import proj_pkg::*;
  localparam int KK = 4;
`ifdef FM_KMER_READER_BASE_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_last = 1'b0, kmer_ready = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, kmer_valid, kmer_last, frag_short, bad_base;
  logic [15:0] kmer_data, kmer_pos;

  int checks = 0, failures = 0;

  logic [7:0]  stim_d[$];
  logic        stim_l[$];
  logic [15:0] exp_d[$], exp_p[$];
  logic        exp_l[$];
  logic [15:0] rcv_d[$], rcv_p[$];
  logic        rcv_l[$];
  int          exp_short;
  logic        exp_bad;

  always #5 clk = ~clk;

  fm_kmer_reader #(.BYTE_W(8), .BASE_W(4), .K(KK)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .kmer_valid(kmer_valid), .kmer_ready(kmer_ready), .kmer_data(kmer_data),
    .kmer_last(kmer_last), .kmer_pos(kmer_pos),
    .frag_short(frag_short), .bad_base(bad_base)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic l);
    stim_d.push_back(d);
    stim_l.push_back(l);
  endtask

  // Sliding-window reference: every base is appended, the window keeps the last K
  task automatic build_model();
    logic [3:0]  win[$];
    logic [3:0]  b;
    logic [15:0] d, p;
    exp_d.delete(); exp_p.delete(); exp_l.delete();
    exp_short = 0; exp_bad = 1'b0; p = '0;
    foreach (stim_d[i]) begin
      for (int h = 0; h < 2; h++) begin
        b = (h == 0) ? stim_d[i][3:0] : stim_d[i][7:4];
        if (CHECK_EN && $countones(b) != 1) begin
          exp_bad = 1'b1;
          win.delete();
        end else begin
          win.push_back(b);
          if (win.size() > KK) void'(win.pop_front());
          if (win.size() == KK) begin
            d = '0;
            foreach (win[j]) d = {d[11:0], win[j]};
            exp_d.push_back(d);
            exp_p.push_back(p);
            exp_l.push_back(h == 1 && stim_l[i]);
            p = p + 16'd1;
          end
        end
        if (h == 1 && stim_l[i]) begin
          if (win.size() < KK) exp_short++;
          win.delete();
          p = '0;
        end
      end
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_in_ready"},   in_ready,   0);
    chk({nm, "_kmer_valid"}, kmer_valid, 0);
    chk({nm, "_kmer_data"},  kmer_data,  0);
    chk({nm, "_kmer_last"},  kmer_last,  0);
    chk({nm, "_kmer_pos"},   kmer_pos,   0);
    chk({nm, "_frag_short"}, frag_short, 0);
    chk({nm, "_bad_base"},   bad_base,   0);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; kmer_ready = 1'b0;
    #1 check_zero(nm);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // mode 0: sink always ready; 1: random valid/ready; 2: sink stalls `stall` cycles
  task automatic run(input string nm, input int mode, input int stall);
    int   idx = 0, got = 0, cyc = 0, quiet = 0, shorts = 0, stall_left = stall;
    logic pv = 1'b0, pl = 1'b0, rdy;
    logic [15:0] pd = '0, pp = '0;
    build_model();
    rcv_d.delete(); rcv_p.delete(); rcv_l.delete();
    while (1) begin
      @(negedge clk);
      if (pv) begin
        chk({nm, "_hold_valid"}, kmer_valid, 1);
        chk({nm, "_hold_data"},  kmer_data,  pd);
        chk({nm, "_hold_pos"},   kmer_pos,   pp);
        chk({nm, "_hold_last"},  kmer_last,  pl);
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 2) != 0);
        default: rdy = !(kmer_valid && stall_left > 0);
      endcase
      if (mode == 2 && !rdy) stall_left--;
      kmer_ready = rdy;
      if (idx < stim_d.size() && (mode != 1 || $urandom_range(0, 3) != 0)) begin
        in_valid = 1'b1; in_data = stim_d[idx]; in_last = stim_l[idx];
      end else begin
        in_valid = 1'b0; in_data = 8'($urandom); in_last = 1'($urandom);
      end
      #1;
      if (mode == 2 && !rdy) chk({nm, "_stall_in_ready"}, in_ready, 0);
      if (frag_short) shorts++;
      if (in_valid && in_ready) idx++;
      if (kmer_valid && kmer_ready) begin
        rcv_d.push_back(kmer_data); rcv_p.push_back(kmer_pos); rcv_l.push_back(kmer_last);
        if (got < exp_d.size()) begin
          chk($sformatf("%s_k%0d_data", nm, got), kmer_data, exp_d[got]);
          chk($sformatf("%s_k%0d_pos", nm, got),  kmer_pos,  exp_p[got]);
          chk($sformatf("%s_k%0d_last", nm, got), kmer_last, exp_l[got]);
        end else begin
          chk({nm, "_extra_kmer"}, got + 1, exp_d.size());
        end
        got++;
      end
      pv = kmer_valid && !kmer_ready; pd = kmer_data; pp = kmer_pos; pl = kmer_last;
      cyc++;
      quiet = (idx == stim_d.size() && !kmer_valid) ? quiet + 1 : 0;
      if (quiet > 8) break;
      if (cyc > 3000) begin
        chk({nm, "_timeout"}, 0, 1);
        break;
      end
    end
    in_valid = 1'b0;
    chk({nm, "_kmer_count"}, got, exp_d.size());
    chk({nm, "_frag_short_count"}, shorts, exp_short);
    chk({nm, "_bad_base"}, bad_base, exp_bad);
    stim_d.delete(); stim_l.delete();
  endtask

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(0, 11) == 0) return 4'($urandom_range(0, 15));
    return 4'b0001 << $urandom_range(0, 3);
  endfunction

  initial begin
    logic [7:0] pre[4];
    int         pi;
    do_reset("reset");

    // single kmer fragment
    do_reset("r1");
    add(8'h21, 0); add(8'h84, 1);
    run("one", 0, 0);
    chk("one_data", rcv_d[0], 16'h1248);
    chk("one_pos",  rcv_p[0], 0);
    chk("one_last", rcv_l[0], 1);

    // three overlapping kmers
    do_reset("r2");
    add(8'h21, 0); add(8'h84, 0); add(8'h12, 1);
    run("three", 0, 0);
    chk("three_d1", rcv_d[1], 16'h2482);
    chk("three_d2", rcv_d[2], 16'h4821);
    chk("three_l0", rcv_l[0], 0);
    chk("three_l2", rcv_l[2], 1);

    // backpressure hold
    do_reset("r3");
    add(8'h21, 0); add(8'h84, 0); add(8'h12, 1);
    run("stall", 2, 5);
    chk("stall_d0", rcv_d[0], 16'h1248);
    chk("stall_cnt", rcv_d.size(), 3);

    // short fragment then normal fragment
    do_reset("r4");
    add(8'h21, 1); add(8'h21, 0); add(8'h84, 1);
    run("short", 0, 0);
    chk("short_d0", rcv_d[0], 16'h1248);
    chk("short_p0", rcv_p[0], 0);

    // async reset while in HI with a kmer pending
    do_reset("r5");
    pre[0] = 8'h21; pre[1] = 8'h84; pre[2] = 8'h12; pre[3] = 8'h48;
    pi = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      kmer_ready = 1'b1; in_valid = 1'b1; in_data = pre[pi]; in_last = 1'b0;
      #1 if (in_ready) pi++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("prerst_valid", kmer_valid, 1);
    chk("prerst_data", kmer_data, 16'h2482);
    rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    rst = 1'b0;
    add(8'h21, 0); add(8'h84, 1);
    run("postrst", 0, 0);
    chk("postrst_d0", rcv_d[0], 16'h1248);
    chk("postrst_p0", rcv_p[0], 0);

    // non-one-hot nibble handling
    do_reset("r6");
    add(8'h31, 0); add(8'h21, 0); add(8'h84, 1);
    run("badnib", 0, 0);
    if (CHECK_EN) begin
      chk("badnib_flag", bad_base, 1);
      chk("badnib_d0", rcv_d[0], 16'h1248);
      chk("badnib_p0", rcv_p[0], 0);
    end else begin
      chk("badnib_flag", bad_base, 0);
      chk("badnib_d0", rcv_d[0], 16'h1312);
      chk("badnib_d1", rcv_d[1], 16'h3124);
      chk("badnib_d2", rcv_d[2], 16'h1248);
    end

    // randomized fragments with random valid/ready
    for (int r = 0; r < 8; r++) begin
      do_reset($sformatf("rr%0d", r));
      for (int f = 0, nf = $urandom_range(3, 6); f < nf; f++) begin
        for (int b = 0, nb = $urandom_range(1, 5); b < nb; b++)
          add({rnd_nib(), rnd_nib()}, b == nb - 1);
      end
      run($sformatf("rand%0d", r), 1, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fm_kmer_reader.md
FM_KMER_READER -- requirements
Module: fm_kmer_reader

Interface
- REQ-001 SHALL have parameter BYTE_W, default GENOME_BTYE (8), genome byte width.
- REQ-002 SHALL have parameter BASE_W, default BASE_LEN (4), one base, one-hot encoded (A=0001, C=0010, G=0100, T=1000).
- REQ-003 SHALL have parameter K, default KMER_LEN (4), bases per kmer.
- REQ-004 SHALL have ports: clk in 1, the single clock.
- REQ-005 SHALL have ports: rst in 1, asynchronous active-high reset.
- REQ-006 SHALL have ports: in_valid in 1, in_ready out 1, in_data in BYTE_W, in_last in 1 (last byte of fragment).
- REQ-007 SHALL have ports: kmer_valid out 1, kmer_ready in 1, kmer_data out K*BASE_W, kmer_last out 1, kmer_pos out 16 (index of the kmer's first base within its fragment).
- REQ-008 SHALL have ports: frag_short out 1, a one-cycle pulse when a fragment ends with fewer than K bases; bad_base out 1, sticky.

Function
- REQ-009 SHALL unpack each accepted byte low nibble first, then high nibble.
- REQ-010 SHALL run an FSM with states IDLE (no byte held), LO (low base pending) and HI (high base pending).
- REQ-011 SHALL move IDLE->LO on accept; LO->HI on advance; HI->LO on advance with a byte accepted the same cycle, else HI->IDLE.
- REQ-012 SHALL define advance = state in {LO,HI} and (!kmer_valid or kmer_ready); a base shifts into the window only on advance.
- REQ-013 SHALL drive in_ready = (state==IDLE) or (state==HI and advance), giving a sustained rate of one byte per 2 cycles.
- REQ-014 SHALL shift each base into the window: newest base in the low nibble, oldest in the high nibble; fill counter saturates at K.
- REQ-015 SHALL register a kmer output on every advance where the post-shift fill equals K; kmer_valid rises the cycle after that edge.
- REQ-016 SHALL hold kmer_data, kmer_pos and kmer_last stable while kmer_valid=1 and kmer_ready=0.
- REQ-017 SHALL drop kmer_valid after a handshake when no new kmer is produced that cycle.
- REQ-018 SHALL set kmer_last=1 on the kmer produced by the high base of the byte that carried in_last.
- REQ-019 SHALL, after that base, clear fill and kmer_pos so the next base starts a new fragment.
- REQ-020 SHALL start kmer_pos at 0 for each fragment, increment it per emitted kmer, and wrap at 2^16.
- REQ-021 SHALL, when a fragment's final base leaves fill < K, emit no kmer, pulse frag_short for 1 cycle and clear the window.
- REQ-022 SHALL latch in_last with its byte; in_last on a byte that is not accepted has no effect.

Reset
- REQ-023 SHALL, on rst assertion and regardless of state or pending handshakes, force: state IDLE, in_ready 0 during reset, kmer_valid 0, kmer_data 0, kmer_last 0, kmer_pos 0, frag_short 0, bad_base 0, fill 0.
- REQ-024 SHALL discard a held byte on reset mid-fragment; the first byte after release starts a new fragment.

Configuration
- REQ-025 SHALL, with FM_KMER_READER_BASE_CHECK_EN defined, flag any non-one-hot nibble: set bad_base (sticky until reset), do not shift that base, and clear fill (window restarts; kmer_pos continues).
- REQ-026 SHALL, without FM_KMER_READER_BASE_CHECK_EN, perform no check, shift every nibble and tie bad_base to 0.

Structure
- REQ-027 SHALL add to proj_pkg: typedef base_t (BASE_LEN bits), typedef kmer_t (KMER_LEN*BASE_LEN bits), constant FM_KMER_POS_W=16 and the one-hot base constants.
- REQ-028 SHALL contain one sub-module, fm_kmer_window, holding the shift register and fill counter with shift, clear and full outputs.

Verification
- REQ-029 SHALL cover: bytes 0x21, 0x84(last), kmer_ready=1 -> one kmer 0x1248, pos 0, kmer_last=1.
- REQ-030 SHALL cover: bytes 0x21, 0x84, 0x12(last) -> kmers 0x1248/0, 0x2482/1, 0x4821/2; last only on 0x4821.
- REQ-031 SHALL cover: as REQ-030 with kmer_ready=0 for 5 cycles -> 0x1248 held stable, in_ready low once HI is blocked, no data lost after release.
- REQ-032 SHALL cover: byte 0x21(last) -> no kmer, frag_short pulses once; next fragment 0x21, 0x84(last) -> 0x1248, pos 0.
- REQ-033 SHALL cover: rst asserted while in HI with kmer_valid=1 -> all outputs 0 immediately; then 0x21, 0x84(last) -> 0x1248, pos 0.
- REQ-034 SHALL cover, with the macro defined: bytes 0x31, 0x21, 0x84(last) -> bad_base=1, single kmer 0x1248, pos 0; without the macro -> bad_base=0 and kmers 0x1312, 0x3124, 0x1248.
